// File: rtl/stream_pkg.sv
// Shared definitions for the UART telemetry streamer.
//   - FSM state encoding
//   - default frame start marker
//   - bytes-per-frame helper
// Optional feature macro: STREAM_CHECKSUM_EN (adds a trailing checksum byte).
package stream_pkg;

  localparam logic [7:0] HDR_BYTE_DEFAULT = 8'hA5;

`ifdef STREAM_CHECKSUM_EN
  localparam int unsigned CSUM_BYTES = 1;
`else
  localparam int unsigned CSUM_BYTES = 0;
`endif

  typedef enum logic [2:0] {
    S_IDLE,
    S_HDR,
    S_SEQ,
    S_DATA,
`ifdef STREAM_CHECKSUM_EN
    S_CSUM,
`endif
    S_HOLD
  } stream_state_e;

  // Header + seq + payload (+ checksum when enabled).
  function automatic int unsigned bytes_per_frame(input int unsigned n_ch,
                                                  input int unsigned ch_w);
    return 2 + (n_ch * ch_w) / 8 + CSUM_BYTES;
  endfunction

endpackage

// File: rtl/stream_byte_sel.sv
// Payload byte selector for the telemetry streamer.
//   snap   : snapshot of all channels, channel 0 in the LSBs
//   idx    : payload byte index 0..N_CH*CH_W/8-1
//   byte_o : selected byte; within each channel the MS byte comes first
module stream_byte_sel #(
  parameter int unsigned N_CH  = 4,
  parameter int unsigned CH_W  = 16,
  parameter int unsigned IDX_W = 3
) (
  input  logic [N_CH*CH_W-1:0] snap,
  input  logic [IDX_W-1:0]     idx,
  output logic [7:0]           byte_o
);

  localparam int unsigned BPC = CH_W / 8;

  int unsigned ch_idx;
  int unsigned byte_in_ch;
  int unsigned bit_off;

  always_comb begin
    ch_idx     = 32'(idx) / BPC;
    byte_in_ch = 32'(idx) % BPC;
    // Byte 0 of a channel is its most significant byte.
    bit_off    = ch_idx * CH_W + (BPC - 1 - byte_in_ch) * 8;
    byte_o     = 8'(snap >> bit_off);
  end

endmodule

// File: rtl/uart_telemetry_streamer.sv
// Autonomous telemetry framer feeding the UART transmit handshake.
// On an accepted (and decimated) sample strobe the channel bus is snapshotted
// and sent as: HDR_BYTE, seq, channel bytes (MS first, channel 0 first)
// and, with STREAM_CHECKSUM_EN defined, a byte making the frame sum to 0.
// Ports:
//   clock, reset      : clock, synchronous active-high reset
//   enable, decim     : streaming enable, frame every decim+1 accepted strobes
//   sample, ch_data   : channel-valid strobe and channel bus
//   txready           : UART can accept a byte
//   txen, txdata      : 1-cycle byte load pulse and byte
//   busy, overruns    : frame in progress, saturating lost-strobe count
// TX_GAP must be >= 1; it sets the HOLD length after every txen pulse.
module uart_telemetry_streamer
  import stream_pkg::*;
#(
  parameter int unsigned N_CH     = 4,
  parameter int unsigned CH_W     = 16,
  parameter logic [7:0]  HDR_BYTE = HDR_BYTE_DEFAULT,
  parameter int unsigned TX_GAP   = 2
) (
  input  logic                 clock,
  input  logic                 reset,
  input  logic                 enable,
  input  logic [7:0]           decim,
  input  logic                 sample,
  input  logic [N_CH*CH_W-1:0] ch_data,
  input  logic                 txready,
  output logic                 txen,
  output logic [7:0]           txdata,
  output logic                 busy,
  output logic [7:0]           overruns
);

  localparam int unsigned NB       = (N_CH * CH_W) / 8;
  localparam int unsigned IDX_W    = (NB > 1) ? $clog2(NB) : 1;
  localparam int unsigned GAP_LAST = (TX_GAP > 1) ? TX_GAP - 1 : 0;
`ifdef STREAM_CHECKSUM_EN
  localparam stream_state_e DATA_EXIT = S_CSUM;
`else
  localparam stream_state_e DATA_EXIT = S_IDLE;
`endif

  stream_state_e         state_q, state_d, ret_q, ret_d, after_byte;
  logic [7:0]            gap_q, gap_d;
  logic [IDX_W-1:0]      idx_q, idx_d;
  logic [7:0]            seq_q, seq_d;
  logic [7:0]            cnt_q, cnt_d;
  logic [N_CH*CH_W-1:0]  snap_q, snap_d;
  logic [7:0]            ovr_q, ovr_d;
  logic                  txen_q, txen_d;
  logic [7:0]            txdata_q, txdata_d;
`ifdef STREAM_CHECKSUM_EN
  logic [7:0]            csum_q, csum_d;
`endif
  logic [7:0]            data_byte;
  logic [7:0]            cur_byte;
  logic                  last_data;

  stream_byte_sel #(
    .N_CH  (N_CH),
    .CH_W  (CH_W),
    .IDX_W (IDX_W)
  ) u_byte_sel (
    .snap   (snap_q),
    .idx    (idx_q),
    .byte_o (data_byte)
  );

  assign last_data = (32'(idx_q) == NB - 1);

  always_ff @(posedge clock) begin
    if (reset) begin
      state_q  <= S_IDLE;
      ret_q    <= S_IDLE;
      gap_q    <= '0;
      idx_q    <= '0;
      seq_q    <= '0;
      cnt_q    <= '0;
      snap_q   <= '0;
      ovr_q    <= '0;
      txen_q   <= 1'b0;
      txdata_q <= '0;
`ifdef STREAM_CHECKSUM_EN
      csum_q   <= '0;
`endif
    end else begin
      state_q  <= state_d;
      ret_q    <= ret_d;
      gap_q    <= gap_d;
      idx_q    <= idx_d;
      seq_q    <= seq_d;
      cnt_q    <= cnt_d;
      snap_q   <= snap_d;
      ovr_q    <= ovr_d;
      txen_q   <= txen_d;
      txdata_q <= txdata_d;
`ifdef STREAM_CHECKSUM_EN
      csum_q   <= csum_d;
`endif
    end
  end

  always_comb begin
    state_d  = state_q;
    ret_d    = ret_q;
    gap_d    = gap_q;
    idx_d    = idx_q;
    seq_d    = seq_q;
    cnt_d    = cnt_q;
    snap_d   = snap_q;
    ovr_d    = ovr_q;
    txen_d   = 1'b0;
    txdata_d = txdata_q;
`ifdef STREAM_CHECKSUM_EN
    csum_d   = csum_q;
`endif

    // Byte to send in the current byte state and the state HOLD returns to.
    cur_byte   = HDR_BYTE;
    after_byte = S_SEQ;
    case (state_q)
      S_SEQ: begin
        cur_byte   = seq_q;
        after_byte = S_DATA;
      end
      S_DATA: begin
        cur_byte   = data_byte;
        after_byte = last_data ? DATA_EXIT : S_DATA;
      end
`ifdef STREAM_CHECKSUM_EN
      S_CSUM: begin
        cur_byte   = 8'd0 - csum_q;
        after_byte = S_IDLE;
      end
`endif
      default: ;
    endcase

    if (!enable) cnt_d = '0;

    case (state_q)
      S_IDLE: begin
        if (sample && enable) begin
          // >= so a decim lowered below the running count fires at once.
          if (cnt_q >= decim) begin
            cnt_d   = '0;
            snap_d  = ch_data;
            idx_d   = '0;
            state_d = S_HDR;
`ifdef STREAM_CHECKSUM_EN
            csum_d  = '0;
`endif
          end else begin
            cnt_d = cnt_q + 8'd1;
          end
        end
      end
      S_HOLD: begin
        if (32'(gap_q) >= GAP_LAST) state_d = ret_q;
        else                        gap_d   = gap_q + 8'd1;
      end
      default: begin
        if (txready) begin
          txen_d   = 1'b1;
          txdata_d = cur_byte;
          gap_d    = '0;
          ret_d    = after_byte;
          state_d  = S_HOLD;
`ifdef STREAM_CHECKSUM_EN
          csum_d   = csum_q + cur_byte;
`endif
          if (state_q == S_DATA) idx_d = last_data ? '0 : idx_q + 1'b1;
          if (after_byte == S_IDLE) seq_d = seq_q + 8'd1;
        end
      end
    endcase

    if (sample && enable && (state_q != S_IDLE) && (ovr_q != 8'hFF))
      ovr_d = ovr_q + 8'd1;
  end

  always_comb begin
    busy     = (state_q != S_IDLE);
    txen     = txen_q;
    txdata   = txdata_q;
    overruns = ovr_q;
  end

endmodule

// File: tb/tb_uart_telemetry_streamer.sv
// Scoreboard bench for uart_telemetry_streamer: stimulus pushes expected frame
// bytes into a queue, a monitor pops and compares on every txen pulse.
// Honours STREAM_CHECKSUM_EN the same way as the design.
module tb_uart_telemetry_streamer;

  localparam int unsigned N_CH   = 4;
  localparam int unsigned CH_W   = 16;
  localparam int unsigned TX_GAP = 2;
  localparam logic [7:0]  HDR    = 8'hA5;
  localparam int unsigned DW     = N_CH * CH_W;
  localparam int unsigned NB     = DW / 8;
`ifdef STREAM_CHECKSUM_EN
  localparam int unsigned FLEN   = NB + 3;
`else
  localparam int unsigned FLEN   = NB + 2;
`endif

  logic          clock = 1'b0;
  logic          reset = 1'b1;
  logic          enable = 1'b0;
  logic [7:0]    decim = '0;
  logic          sample = 1'b0;
  logic [DW-1:0] ch_data = '0;
  logic          txready = 1'b1;
  logic          txen;
  logic [7:0]    txdata;
  logic          busy;
  logic [7:0]    overruns;

  uart_telemetry_streamer #(
    .N_CH     (N_CH),
    .CH_W     (CH_W),
    .HDR_BYTE (HDR),
    .TX_GAP   (TX_GAP)
  ) dut (
    .clock    (clock),
    .reset    (reset),
    .enable   (enable),
    .decim    (decim),
    .sample   (sample),
    .ch_data  (ch_data),
    .txready  (txready),
    .txen     (txen),
    .txdata   (txdata),
    .busy     (busy),
    .overruns (overruns)
  );

  always #5 clock = ~clock;

  int unsigned cyc = 0;
  always @(posedge clock) cyc <= cyc + 1;

  int tests = 0;
  int fails = 0;

  logic [7:0]  exp_q[$];
  int unsigned txen_cyc_q[$];
  int unsigned txen_cnt = 0;
  int unsigned prev_txen = 0;
  bit          have_prev = 1'b0;

  // Reference model state
  logic [7:0] seq_m = '0;
  logic [7:0] cnt_m = '0;
  logic [7:0] ovr_m = '0;
  logic [7:0] decim_m = '0;
  bit         en_m = 1'b0;

  task automatic check(input string name, input longint act, input longint exp);
    tests++;
    if (act != exp) begin
      fails++;
      $display("FAIL %s: got %0h expected %0h (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  task automatic push_frame(input logic [DW-1:0] snap);
    logic [7:0]    sum;
    logic [DW-1:0] w;
    sum = HDR + seq_m;
    exp_q.push_back(HDR);
    exp_q.push_back(seq_m);
    for (int ch = 0; ch < int'(N_CH); ch++) begin
      w = snap >> (ch * CH_W);
      for (int k = int'(CH_W / 8) - 1; k >= 0; k--) begin
        exp_q.push_back(w[k*8 +: 8]);
        sum = sum + w[k*8 +: 8];
      end
    end
`ifdef STREAM_CHECKSUM_EN
    exp_q.push_back(8'd0 - sum);
`endif
    seq_m = seq_m + 8'd1;
  endtask

  task automatic model_strobe(input logic [DW-1:0] d, input bit idle);
    if (!en_m) return;
    if (!idle) begin
      if (ovr_m != 8'hFF) ovr_m = ovr_m + 8'd1;
    end else if (cnt_m >= decim_m) begin
      push_frame(d);
      cnt_m = '0;
    end else begin
      cnt_m = cnt_m + 8'd1;
    end
  endtask

  task automatic step(input int n);
    repeat (n) begin
      @(posedge clock);
      #2;
    end
  endtask

  task automatic pulse(input logic [DW-1:0] d);
    ch_data = d;
    sample  = 1'b1;
    @(posedge clock);
    #2;
    sample  = 1'b0;
  endtask

  task automatic do_strobe(input logic [DW-1:0] d, input bit idle);
    model_strobe(d, idle);
    pulse(d);
  endtask

  task automatic set_decim(input logic [7:0] v);
    decim   = v;
    decim_m = v;
  endtask

  task automatic set_enable(input bit v);
    enable = v;
    en_m   = v;
    if (!v) cnt_m = '0;
  endtask

  task automatic do_reset();
    reset = 1'b1;
    exp_q.delete();
    seq_m = '0;
    cnt_m = '0;
    ovr_m = '0;
    step(3);
    reset = 1'b0;
    step(1);
  endtask

  task automatic drain(input int budget, input bit rnd_ready);
    for (int i = 0; i < budget && exp_q.size() != 0; i++) begin
      if (rnd_ready) txready = 1'($urandom_range(0, 1));
      step(1);
    end
    txready = 1'b1;
    check("drain_empty", exp_q.size(), 0);
    step(3);
    check("busy_after_frame", busy, 0);
  endtask

  function automatic logic [DW-1:0] rnd_data();
    return {$urandom(), $urandom()};
  endfunction

  // Monitor: every txen pulse must match the next expected byte.
  initial begin
    forever begin
      @(posedge clock);
      #1;
      if (txen) begin
        txen_cnt++;
        txen_cyc_q.push_back(cyc);
        if (have_prev) check("txen_min_spacing", (cyc - prev_txen) >= TX_GAP + 1, 1);
        prev_txen = cyc;
        have_prev = 1'b1;
        if (exp_q.size() == 0) begin
          tests++;
          fails++;
          $display("FAIL unexpected_txen: got byte %0h expected no txen (cycle %0d)", txdata, cyc);
        end else begin
          check("txdata", txdata, exp_q.pop_front());
        end
      end
    end
  end

  initial begin
    #500000;
    $display("FAIL watchdog: time limit reached with %0d bytes outstanding", exp_q.size());
    $fatal(1, "watchdog");
  end

  initial begin
    logic [7:0]  t2 [10];
    logic [7:0]  sum;
    int unsigned trig, n0, n1;

    // Reset values
    step(3);
    check("rst_txen", txen, 0);
    check("rst_txdata", txdata, 0);
    check("rst_busy", busy, 0);
    check("rst_overruns", overruns, 0);
    reset = 1'b0;
    step(2);
    set_enable(1'b1);
    set_decim(8'd0);

    // Directed frame with literal expected bytes and exact pulse spacing
    t2 = '{8'hA5, 8'h00, 8'h11, 8'h11, 8'h22, 8'h22, 8'h33, 8'h33, 8'h44, 8'h44};
    sum = '0;
    foreach (t2[i]) begin
      exp_q.push_back(t2[i]);
      sum = sum + t2[i];
    end
`ifdef STREAM_CHECKSUM_EN
    exp_q.push_back(8'd0 - sum);
`endif
    seq_m = 8'd1;
    txen_cyc_q.delete();
    pulse({16'h4444, 16'h3333, 16'h2222, 16'h1111});
    trig = cyc;
    drain(200, 1'b0);
    check("t2_txen_count", txen_cyc_q.size(), FLEN);
    check("t2_first_latency", (txen_cyc_q.size() > 0) ? txen_cyc_q[0] : 0, trig + 1);
    for (int i = 1; i < txen_cyc_q.size(); i++)
      check("t2_spacing", txen_cyc_q[i] - txen_cyc_q[i-1], TX_GAP + 1);

    // Decimation: decim=2, 9 strobes 40 cycles apart -> strobes 3,6,9 frame
    do_reset();
    set_decim(8'd2);
    n0 = txen_cnt;
    for (int i = 0; i < 9; i++) begin
      do_strobe(rnd_data(), 1'b1);
      step(39);
    end
    drain(200, 1'b0);
    check("t3_txen_total", txen_cnt - n0, 3 * FLEN);

    // Overruns: strobes mid-frame leave the snapshot alone
    set_decim(8'd0);
    do_strobe(rnd_data(), 1'b1);
    for (int i = 0; i < 5; i++) begin
      step(4);
      do_strobe(rnd_data(), 1'b0);
    end
    drain(200, 1'b0);
    check("t4_overruns", overruns, ovr_m);
    txready = 1'b0;
    do_strobe(rnd_data(), 1'b1);
    for (int i = 0; i < 300; i++) begin
      step(1);
      do_strobe(rnd_data(), 1'b0);
    end
    check("t4_overruns_sat", overruns, 8'hFF);
    check("t4_overruns_model", overruns, ovr_m);
    txready = 1'b1;
    drain(200, 1'b0);

    // txready stall after the header
    n0 = txen_cnt;
    do_strobe(rnd_data(), 1'b1);
    for (int i = 0; i < 20 && txen_cnt == n0; i++) step(1);
    check("t5_header_seen", txen_cnt - n0, 1);
    txready = 1'b0;
    n1 = txen_cnt;
    step(100);
    check("t5_no_txen_stall", txen_cnt, n1);
    check("t5_busy_stall", busy, 1);
    txready = 1'b1;
    drain(200, 1'b0);

    // enable drops after the 4th byte; frame completes, next strobe ignored
    n0 = txen_cnt;
    do_strobe(rnd_data(), 1'b1);
    for (int i = 0; i < 60 && (txen_cnt - n0) < 4; i++) step(1);
    set_enable(1'b0);
    drain(200, 1'b0);
    check("t6_frame_len", txen_cnt - n0, FLEN);
    n1 = txen_cnt;
    do_strobe(rnd_data(), 1'b1);
    step(40);
    check("t6_no_frame", txen_cnt, n1);
    check("t6_no_overrun", overruns, ovr_m);
    set_enable(1'b1);

    // Reset after the 3rd byte aborts the frame
    n0 = txen_cnt;
    do_strobe(rnd_data(), 1'b1);
    for (int i = 0; i < 60 && (txen_cnt - n0) < 3; i++) step(1);
    check("t7_three_bytes", txen_cnt - n0, 3);
    reset = 1'b1;
    exp_q.delete();
    seq_m = '0;
    cnt_m = '0;
    ovr_m = '0;
    n1 = txen_cnt;
    step(1);
    check("t7_txen", txen, 0);
    check("t7_txdata", txdata, 0);
    check("t7_busy", busy, 0);
    check("t7_overruns", overruns, 0);
    step(2);
    reset = 1'b0;
    step(10);
    check("t7_no_txen_after_reset", txen_cnt, n1);
    do_strobe(rnd_data(), 1'b1);
    drain(200, 1'b0);

    // Randomized frames with random decim, txready and enable glitches
    for (int it = 0; it < 40; it++) begin
      set_decim(8'($urandom_range(0, 3)));
      if ($urandom_range(0, 7) == 0) begin
        set_enable(1'b0);
        step(1);
        set_enable(1'b1);
      end
      do_strobe(rnd_data(), 1'b1);
      drain(400, 1'b1);
      step($urandom_range(0, 3));
    end

    check("final_overruns", overruns, ovr_m);
    check("final_queue_empty", exp_q.size(), 0);
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
